// File: rtl/shifter_ctrl.sv
// Button front-end and start/direction controller for the 4-bit running-light shifter.
// Synchronizes and debounces two buttons, sequences the shifter start pulse and owns the direction flag.
module shifter_ctrl #(
    parameter int DEB_CYCLES  = 4,
    parameter int RST_HOLD    = 2,
    parameter int AUTO_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start,
    input  logic btn_dir,
    input  logic auto_rev,
    output logic shifter_rst,
    output logic flag,
    output logic running
);

    localparam int DW = $clog2(DEB_CYCLES) + 1;
    localparam int HW = $clog2(RST_HOLD) + 1;
    localparam int AW = $clog2(AUTO_PERIOD) + 1;

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD - 1);
    localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Index 0 is the start button, index 1 the direction button.
    logic [1:0]    sync1_q, sync2_q, stable_q, stable_d, stable_dly_q;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];
    logic [1:0]    press;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [AW-1:0] auto_q, auto_d;
    logic          flag_q, flag_d;
    logic          shifter_rst_q, shifter_rst_d;
    logic          running_q, running_d;
    logic          start_press, dir_press, auto_expire;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i]  = stable_q[i];
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DEB_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press       = stable_q & ~stable_dly_q;
    assign start_press = press[0];
    assign dir_press   = press[1];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (start_press) begin
                    state_d = INIT;
                    hold_d  = '0;
                end
            end
            INIT: begin
                if (hold_q == HOLD_MAX) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (start_press) begin
                    state_d = INIT;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // A manual press and an auto expiry in the same cycle toggle the flag only once.
    always_comb begin
        auto_expire = (state_q == RUN) && auto_rev && (auto_q == AUTO_MAX);
        flag_d      = flag_q ^ (dir_press | auto_expire);
        auto_d      = '0;
        if ((state_q == RUN) && auto_rev && !dir_press && !auto_expire) begin
            auto_d = auto_q + 1'b1;
        end
        shifter_rst_d = (state_d == INIT);
        running_d     = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_dly_q  <= '0;
            deb_cnt_q[0]  <= '0;
            deb_cnt_q[1]  <= '0;
            state_q       <= IDLE;
            hold_q        <= '0;
            auto_q        <= '0;
            flag_q        <= 1'b0;
            shifter_rst_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            sync1_q       <= {btn_dir, btn_start};
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_dly_q  <= stable_q;
            deb_cnt_q[0]  <= deb_cnt_d[0];
            deb_cnt_q[1]  <= deb_cnt_d[1];
            state_q       <= state_d;
            hold_q        <= hold_d;
            auto_q        <= auto_d;
            flag_q        <= flag_d;
            shifter_rst_q <= shifter_rst_d;
            running_q     <= running_d;
        end
    end

    assign shifter_rst = shifter_rst_q;
    assign flag        = flag_q;
    assign running     = running_q;

endmodule

// File: tb/tb_shifter_ctrl.sv
// Bench for shifter_ctrl: directed timing scenarios plus random button activity,
// every cycle compared against an event-level reference model.
module tb_shifter_ctrl;

  localparam int DEB_CYCLES  = 4;
  localparam int RST_HOLD    = 2;
  localparam int AUTO_PERIOD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_start = 1'b0;
  logic btn_dir = 1'b0;
  logic auto_rev = 1'b0;
  logic shifter_rst, flag, running;

  int n_checks = 0;
  int n_fail = 0;

  shifter_ctrl #(
    .DEB_CYCLES(DEB_CYCLES),
    .RST_HOLD(RST_HOLD),
    .AUTO_PERIOD(AUTO_PERIOD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_start(btn_start),
    .btn_dir(btn_dir),
    .auto_rev(auto_rev),
    .shifter_rst(shifter_rst),
    .flag(flag),
    .running(running)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0=idle, 1=start pulse in progress, 2=running.
  int m_s1[2], m_s2[2], m_stab[2], m_run[2], m_pend[2];
  int m_phase, m_left, m_flag, m_since;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0; m_run[b] = 0; m_pend[b] = 0;
    end
    m_phase = 0; m_left = 0; m_flag = 0; m_since = 0;
  endfunction

  function automatic void model_step(input int raw_s, input int raw_d, input int ar);
    int sp, dp, tog;
    int raw[2];
    raw[0] = raw_s;
    raw[1] = raw_d;
    sp = m_pend[0];
    dp = m_pend[1];
    tog = dp;
    if (m_phase == 2 && ar != 0 && dp == 0) begin
      m_since++;
      if (m_since == AUTO_PERIOD) begin
        tog = 1;
        m_since = 0;
      end
    end else begin
      m_since = 0;
    end
    m_flag = m_flag ^ tog;
    case (m_phase)
      0: if (sp != 0) begin m_phase = 1; m_left = RST_HOLD; end
      1: begin m_left--; if (m_left == 0) m_phase = 2; end
      default: if (sp != 0) begin m_phase = 1; m_left = RST_HOLD; end
    endcase
    for (int b = 0; b < 2; b++) begin
      m_pend[b] = 0;
      if (m_s2[b] != m_stab[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB_CYCLES) begin
          m_stab[b] = m_s2[b];
          m_run[b] = 0;
          m_pend[b] = m_stab[b];
        end
      end else begin
        m_run[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: advance the model, then compare all outputs off the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step(int'(btn_start), int'(btn_dir), int'(auto_rev));
    #1;
    check_eq("mdl_shifter_rst", int'(shifter_rst), int'(m_phase == 1));
    check_eq("mdl_running", int'(running), int'(m_phase == 2));
    check_eq("mdl_flag", int'(flag), m_flag);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_timing();
    btn_start = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check_eq($sformatf("start_rst_E%0d", e), int'(shifter_rst), int'(e == 7 || e == 8));
      check_eq($sformatf("start_run_E%0d", e), int'(running), int'(e >= 9));
    end
    btn_start = 1'b0;
    wait_ticks(10);
  endtask

  initial begin
    model_reset();
    // Reset then idle
    wait_ticks(3);
    check_eq("reset_flag", int'(flag), 0);
    check_eq("reset_shifter_rst", int'(shifter_rst), 0);
    check_eq("reset_running", int'(running), 0);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check_eq("idle_quiet", int'(flag | shifter_rst | running), 0);
    end

    // Bounce rejection: sync2 high only 2 cycles at a time
    for (int i = 0; i < 20; i++) begin
      btn_start = ((i / 2) % 2 == 0);
      tick();
      check_eq("bounce_rst", int'(shifter_rst), 0);
    end
    btn_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bounce_idle", int'(shifter_rst | running), 0);
    end

    start_timing();

    // Direction in RUN, held button toggles once
    btn_dir = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check_eq($sformatf("dir1_E%0d", e), int'(flag), int'(e >= 7));
    end
    btn_dir = 1'b0;
    wait_ticks(10);
    btn_dir = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_eq($sformatf("dir2_E%0d", e), int'(flag), int'(e < 7));
    end
    btn_dir = 1'b0;
    wait_ticks(10);

    // Auto-reverse from a fresh RUN entry (restart), flag starts at 0
    btn_start = 1'b1;
    wait_ticks(7);
    auto_rev = 1'b1;
    wait_ticks(2);
    btn_start = 1'b0;
    check_eq("auto1_entry_run", int'(running), 1);
    for (int k = 1; k <= 24; k++) begin
      tick();
      check_eq($sformatf("auto1_k%0d", k), int'(flag), (k / AUTO_PERIOD) % 2);
    end
    auto_rev = 1'b0;

    // Manual press reacting on edge 5 after entry restarts the auto period
    btn_start = 1'b1;
    wait_ticks(7);
    auto_rev = 1'b1;
    btn_dir = 1'b1;
    wait_ticks(2);
    btn_start = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      check_eq($sformatf("auto2_k%0d", k), int'(flag),
               1 ^ int'(k >= 5) ^ int'(k >= 13) ^ int'(k >= 21));
    end
    auto_rev = 1'b0;
    btn_dir = 1'b0;
    wait_ticks(12);
    btn_dir = 1'b1;
    wait_ticks(8);
    btn_dir = 1'b0;
    check_eq("pre_rst_flag", int'(flag), 1);
    check_eq("pre_rst_running", int'(running), 1);
    wait_ticks(10);

    // Mid-operation asynchronous reset between edges
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst_flag", int'(flag), 0);
    check_eq("async_rst_running", int'(running), 0);
    check_eq("async_rst_shifter_rst", int'(shifter_rst), 0);
    #1;
    rst = 1'b1;
    wait_ticks(3);
    start_timing();

    // Random button activity against the model
    for (int seg = 0; seg < 120; seg++) begin
      btn_start = ($urandom_range(0, 3) == 0);
      btn_dir = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) auto_rev = $urandom_range(0, 1);
      wait_ticks($urandom_range(1, 14));
    end
    btn_start = 1'b0;
    btn_dir = 1'b0;
    wait_ticks(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shifter_ctrl.md
Name: shifter_ctrl

Overview:
- Front-end control stage that directly drives the 4-bit running-light shifter's `rst` and `flag` inputs.
- Conditions two raw push-buttons: 2-flop synchronizer, debounce, rising-edge press detect.
- A 3-state FSM issues the shifter start/restart pulse and owns the direction flag.
- Optional auto-reverse mode toggles direction at a fixed period while running.

Parameters:
- DEB_CYCLES, 4, consecutive cycles a synchronized input must differ from its stable value before the stable value changes (>=1).
- RST_HOLD, 2, number of cycles shifter_rst is held high per start/restart (>=1).
- AUTO_PERIOD, 8, RUN cycles between automatic direction toggles (>=2).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_start  in  1  raw start/restart button, active-high, asynchronous to clk.
- btn_dir  in  1  raw direction button, active-high, asynchronous to clk.
- auto_rev  in  1  synchronous level; 1 enables auto-reverse in RUN.
- shifter_rst  out  1  registered; active-high start pulse to the shifter's rst.
- flag  out  1  registered; shifter direction (1 = right-to-left, 0 = left-to-right).
- running  out  1  registered; 1 while FSM is in RUN.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; flag=0; shifter_rst=0; running=0; sync flops, stable values, debounce counters and auto counter all cleared. Asserting reset mid-operation forces these values immediately, without waiting for clk.
- Synchronizer: 2 flops per button.
- Debounce, per button: counter clears whenever sync2==stable. Otherwise it increments. When sync2!=stable and the counter==DEB_CYCLES-1, stable<=sync2 and the counter clears.
- Press event: combinational stable & ~stable_d (stable_d is a 1-cycle delay). It lasts exactly one cycle per debounced rising edge. Release produces no event.
- Latency: for a raw input held high from before edge E1 (the first edge sampling it), stable rises at edge E(DEB_CYCLES+2) and the FSM/flag reacts at edge E(DEB_CYCLES+3).
- Glitch rejection: a raw pulse that leaves sync2 high for fewer than DEB_CYCLES consecutive cycles produces no event.
- FSM state IDLE:
  - shifter_rst=0, running=0.
  - Start press -> INIT; hold counter cleared.
- FSM state INIT:
  - shifter_rst=1, running=0.
  - shifter_rst rises on the edge entering INIT and stays high for exactly RST_HOLD cycles.
  - On the RST_HOLD-th edge -> RUN.
  - Start presses during INIT are ignored.
- FSM state RUN:
  - shifter_rst=0, running=1.
  - Start press -> INIT (restart: shifter re-homed, flag unchanged).
  - No stop path; only rst returns to IDLE.
- Direction:
  - A dir press toggles flag on the reacting edge, in any state including IDLE and INIT.
- Auto-reverse:
  - Auto counter is 0 on entry to RUN and increments each RUN cycle while auto_rev=1.
  - On the edge where counter==AUTO_PERIOD-1: flag toggles and counter clears. The first toggle is therefore the AUTO_PERIOD-th edge after RUN entry.
  - Counter is cleared while auto_rev=0, outside RUN, and on any manual dir press.
- Simultaneous events:
  - Manual dir press and auto expiry in the same cycle -> flag toggles once; counter clears.
  - Start press and dir press in the same cycle -> both take effect.
- Widths: all counters are sized as clog2(param)+1 bits; no wrap is possible within legal parameter ranges.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then 1; buttons low -> flag=0, shifter_rst=0, running=0 for 50 cycles.
- Start press (defaults): btn_start high from edge E1 onward:
  - shifter_rst=1 after E7 and E8.
  - shifter_rst=0 and running=1 after E9.
- Bounce rejection: btn_start toggled every 2 cycles for 20 cycles, then low -> no shifter_rst pulse, state stays IDLE.
- Direction in RUN, auto_rev=0: btn_dir held 10 cycles -> exactly one flag toggle (0->1) at E7; held button does not re-toggle; a second clean press -> flag=0.
- Auto-reverse: auto_rev=1 from RUN entry (AUTO_PERIOD=8) -> flag toggles at the 8th, 16th and 24th edges after entry. A manual dir press reacting on edge 5 -> single toggle at edge 5, next auto toggle at edge 13.
- Mid-operation reset: in RUN with flag=1, drive rst=0 between clock edges -> flag, running and shifter_rst go 0 immediately. After release, a start press repeats the E7/E9 timing.
